uart_tx_feeder: RTL and testbench



---
 rtl/uart_tx_feeder.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch FSM feeding one UART transmitter.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   wr_en     push request, with wr_data as the byte to push
//   flush     synchronous FIFO clear (in-flight byte is not aborted)
//   clr_err   synchronous clear of overflow and tx_err (a same-cycle set wins)
//   tx_done   one-cycle completion pulse from the UART transmitter
//   tx_start  one-cycle launch pulse to the UART transmitter
//   data_out  byte presented to the UART data_in
//   full      count == DEPTH
//   empty     count == 0
//   count     bytes currently buffered
//   busy      launch FSM is not idle
//   overflow  sticky: a push was dropped because the FIFO was full
//   tx_err    sticky: the tx_done watchdog expired
//
// All outputs come straight from flops.
module uart_tx_feeder #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD_RATE      = 19200,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = (CLK_FREQ / BAUD_RATE) * 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    input  logic                   clr_err,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [7:0]             data_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   overflow,
    output logic                   tx_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e           state_q,    state_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             full_q,     full_d;
    logic             empty_q,    empty_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q,     busy_d;
    logic             overflow_q, overflow_d;
    logic             tx_err_q,   tx_err_d;
    logic [TMR_W-1:0] timer_q,    timer_d;

    logic [7:0] mem [DEPTH];

    logic push_ok;
    logic pop;
    logic timeout;

    // Next-state, FIFO bookkeeping and output computation.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        tx_start_d = 1'b0;
        timer_d    = timer_q;
        pop        = 1'b0;
        timeout    = 1'b0;

        // Full is judged on the registered value, so a same-cycle pop never
        // makes room for a push.
        push_ok = wr_en & ~full_q & ~flush;

        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    data_out_d = mem[rd_ptr_q];
                    state_d    = S_START;
                end
            end
            S_START: begin
                tx_start_d = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // tx_done takes priority over an expiring watchdog.
                if (tx_done) begin
                    state_d = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
                if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        busy_d  = (state_d != S_IDLE);

        // Sticky flags: a new event in the clearing cycle keeps the flag set.
        overflow_d = (overflow_q & ~clr_err) | (wr_en & full_q & ~flush);
        tx_err_d   = (tx_err_q & ~clr_err) | timeout;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            data_out_q <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_err_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            data_out_q <= data_out_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            tx_err_q   <= tx_err_d;
            timer_q    <= timer_d;
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign tx_start = tx_start_q;
    assign data_out = data_out_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int TMO   = 100;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_err;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic       overflow;
    logic       tx_err;

    uart_tx_feeder #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_err  (clr_err),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .busy     (busy),
        .overflow (overflow),
        .tx_err   (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: buffered bytes, sticky flags, and the in-flight byte
    // described by the edge number at which it was popped.
    logic [7:0] m_q [$];
    logic [7:0] m_dout;
    bit         m_ovf;
    bit         m_err;
    bit         m_active;
    int         m_tpop;
    int         cyc;

    int         n_cmp;
    int         n_bad;
    int         n_starts;
    logic [7:0] seen [$];

    // UART stand-in: fixed reply delay after tx_start (-1 = never), or random.
    int         done_dly;
    bit         done_rand;
    int         done_span;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout   = 8'h00;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        m_active = 1'b0;
        m_tpop   = -1000;
    endtask

    // Apply the rules for one rising edge using the inputs held across it.
    // tx_start is visible in the cycle after edge m_tpop+1; tx_done is
    // honoured from edge m_tpop+2 on, and the watchdog gives TMO such edges.
    task automatic model_edge();
        int  k;
        bit  full_pre;
        bit  pop_now;
        bit  err_set;
        bit  ovf_set;
        k        = cyc + 1;
        full_pre = (m_q.size() == DEPTH);
        ovf_set  = wr_en && full_pre && !flush;
        err_set  = 1'b0;
        pop_now  = !m_active && (m_q.size() != 0);
        if (m_active && k >= m_tpop + 2) begin
            if (tx_done) begin
                m_active = 1'b0;
            end else if (k - (m_tpop + 2) == TMO - 1) begin
                err_set  = 1'b1;
                m_active = 1'b0;
            end
        end
        if (pop_now) begin
            m_dout   = m_q.pop_front();
            m_active = 1'b1;
            m_tpop   = k;
        end
        if (flush) m_q.delete();
        else if (wr_en && !full_pre) m_q.push_back(wr_data);
        if (clr_err) begin
            m_ovf = 1'b0;
            m_err = 1'b0;
        end
        if (ovf_set) m_ovf = 1'b1;
        if (err_set) m_err = 1'b1;
        cyc = k;
    endtask

    task automatic compare_all();
        check_eq("tx_start", 32'(tx_start), 32'(m_active && (cyc == m_tpop + 1)));
        check_eq("data_out", 32'(data_out), 32'(m_dout));
        check_eq("count",    32'(count),    32'(m_q.size()));
        check_eq("full",     32'(full),     32'(m_q.size() == DEPTH));
        check_eq("empty",    32'(empty),    32'(m_q.size() == 0));
        check_eq("busy",     32'(busy),     32'(m_active));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("tx_err",   32'(tx_err),   32'(m_err));
    endtask

    task automatic step();
        if (done_rand) tx_done = ($urandom_range(0, done_span - 1) == 0);
        else tx_done = m_active && (done_dly >= 0) && (cyc == m_tpop + 1 + done_dly);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (tx_start) begin
            n_starts++;
            seen.push_back(data_out);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        wr_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        tx_done = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        cyc++;
        #1;
        compare_all();
        rst = 1'b1;
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(first + 8'(i));
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (m_active || m_q.size() != 0); i++) step();
        step();
        check_eq("drain_busy",  32'(busy),  32'd0);
        check_eq("drain_count", 32'(count), 32'd0);
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int e0;
        int t_s;
        n_cmp = 0; n_bad = 0; n_starts = 0; cyc = 0;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
        clr_err = 1'b0; tx_done = 1'b0;
        done_rand = 1'b0; done_dly = -1; done_span = 8;
        model_reset();
        #2;
        do_reset();

        // Single byte into an idle feeder: tx_start two edges after the push.
        done_dly = 50;
        push_seq(8'hA5, 1);
        e0 = cyc;
        for (int i = 0; i < 10 && !tx_start; i++) step();
        check_eq("t1_latency", 32'(cyc - e0), 32'd2);
        check_eq("t1_data", 32'(data_out), 32'hA5);
        drain(200);

        // Burst ordering.
        done_dly = 20; n_starts = 0; seen.delete();
        push_seq(8'h01, 5);
        drain(500);
        check_eq("t2_starts", 32'(n_starts), 32'd5);
        for (int i = 0; i < 5; i++)
            check_eq("t2_order", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF, 32'(i + 1));
        check_eq("t2_empty", 32'(empty), 32'd1);

        // Overflow with tx_done withheld.
        done_dly = -1;
        push_seq(8'h10, 18);
        check_eq("t3_count",    32'(count),    32'd16);
        check_eq("t3_full",     32'(full),     32'd1);
        check_eq("t3_overflow", 32'(overflow), 32'd1);
        check_eq("t3_data",     32'(data_out), 32'h10);
        clear_errs();
        check_eq("t3_ovf_clr",  32'(overflow), 32'd0);
        flush = 1'b1; step(); flush = 1'b0;
        drain(300);

        // Wrap-around: three drained rounds of twelve.
        done_dly = 3;
        clear_errs();
        for (int r = 0; r < 3; r++) begin
            seen.delete();
            push_seq(8'(8'h40 + 8'(r * 12)), 12);
            drain(400);
            check_eq("t4_nbytes", 32'(seen.size()), 32'd12);
            for (int j = 0; j < 12; j++)
                check_eq("t4_order", (j < seen.size()) ? 32'(seen[j]) : 32'hFFFF,
                         32'(8'h40 + r * 12 + j));
        end

        // Watchdog: tx_err exactly TMO cycles after START, then next byte.
        done_dly = -1;
        push_seq(8'h3C, 1);
        push_seq(8'h5A, 1);
        for (int i = 0; i < 20 && !tx_start; i++) step();
        t_s = cyc;
        for (int i = 0; i < 300 && !tx_err; i++) step();
        check_eq("t5_wdog_delay", 32'(cyc - t_s), 32'd100);
        check_eq("t5_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 10 && !tx_start; i++) step();
        check_eq("t5_second_start", 32'(tx_start), 32'd1);
        check_eq("t5_second_data", 32'(data_out), 32'h5A);
        done_dly = 5;
        drain(300);

        // Flush during WAIT: in-flight byte finishes, nothing else launches.
        clear_errs();
        done_dly = 40; n_starts = 0;
        push_seq(8'hC1, 4);
        for (int i = 0; i < 5; i++) step();
        flush = 1'b1; step(); flush = 1'b0;
        check_eq("t6_flush_count", 32'(count),    32'd0);
        check_eq("t6_flush_empty", 32'(empty),    32'd1);
        check_eq("t6_flush_data",  32'(data_out), 32'hC1);
        drain(200);
        check_eq("t6_flush_starts", 32'(n_starts), 32'd1);

        // Reset while the second byte sits in START.
        done_dly = 10;
        push_seq(8'hD0, 4);
        for (int i = 0; i < 100 && !(m_active && cyc == m_tpop && m_dout == 8'hD1); i++) step();
        check_eq("t6_in_start", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("t6_rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("t6_rst_count",    32'(count),    32'd0);
        check_eq("t6_rst_data",     32'(data_out), 32'h00);
        do_reset();

        // Random traffic: fast replies, then slow replies that hit the watchdog.
        done_rand = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            done_span = (ph == 0) ? 8 : 200;
            for (int i = 0; i < 2500; i++) begin
                wr_en   = ($urandom_range(0, 2) == 0);
                wr_data = 8'($urandom);
                flush   = ($urandom_range(0, 149) == 0);
                clr_err = ($urandom_range(0, 59) == 0);
                step();
            end
        end
        wr_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        done_rand = 1'b0; done_dly = 2;
        drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
